// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file with write-through bypass, immediate
// generation, control decode, load-use / branch hazard detection and early branch resolution.
module id_stage #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PC_WIDTH-1:0]   if_pc,
  input  logic [PC_WIDTH-1:0]   if_pc_next,
  input  logic [INST_WIDTH-1:0] if_inst,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [4:0]            ex_rd,
  input  logic                  mem_mem_read,
  input  logic                  mem_reg_write,
  input  logic [4:0]            mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic                  wb_reg_write,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  pc_sel,
  output logic [PC_WIDTH-1:0]   pc_imm,
  output logic                  pc_write,
  output logic                  IF_flush,
  output logic                  IF_ID_write,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [PC_WIDTH-1:0]   id_pc_next,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [2:0]            funct3,
  output logic [3:0]            alu_op,
  output logic                  alu_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  jump,
  output logic                  illegal
);

  localparam logic [INST_WIDTH-1:0] INST_NOP = INST_WIDTH'(32'h0000_0013);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // alu_op is {inst[30], funct3} for OP/OP-IMM; PASSB forwards the immediate for LUI
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc_next_q, pc_next_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] regs_d [32];

  logic [6:0]            opcode;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]            dec_alu_op;
  logic                  dec_alu_src, dec_mem_read, dec_mem_write, dec_reg_write;
  logic                  dec_mem_to_reg, dec_jump, legal;
  logic                  use_rs1, use_rs2, is_branch, is_jal, is_jalr;
  logic                  load_use, br_haz_1, br_haz_2, stall, ctrl_en;
  logic [DATA_WIDTH-1:0] br_op1, br_op2, jalr_sum;
  logic                  br_cond;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_q    <= INST_NOP;
      pc_q      <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      regs_q    <= regs_d;
    end
  end

  // Flush wins over capture so a redirected fetch never reaches decode
  always_comb begin
    inst_d    = inst_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (IF_flush) begin
      inst_d  = INST_NOP;
      valid_d = 1'b0;
    end else if (IF_ID_write) begin
      inst_d    = if_inst;
      pc_d      = if_pc;
      pc_next_d = if_pc_next;
      valid_d   = 1'b1;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_reg_write && wb_rd != 5'd0) regs_d[wb_rd] = wb_data;
  end

  assign opcode = inst_q[6:0];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign rd     = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign id_pc      = pc_q;
  assign id_pc_next = pc_next_q;

  always_comb begin
    rs1_data = regs_q[rs1];
    if (rs1 == 5'd0) rs1_data = '0;
    else if (wb_reg_write && wb_rd == rs1) rs1_data = wb_data;
    rs2_data = regs_q[rs2];
    if (rs2 == 5'd0) rs2_data = '0;
    else if (wb_reg_write && wb_rd == rs2) rs2_data = wb_data;
  end

  assign imm_i = {{(DATA_WIDTH-11){inst_q[31]}}, inst_q[30:20]};
  assign imm_s = {{(DATA_WIDTH-11){inst_q[31]}}, inst_q[30:25], inst_q[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-31){inst_q[31]}}, inst_q[30:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-20){inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  always_comb begin
    imm            = imm_i;
    dec_alu_op     = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_jump       = 1'b0;
    legal          = 1'b1;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    is_branch      = 1'b0;
    is_jal         = 1'b0;
    is_jalr        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm = imm_u; dec_alu_op = ALU_PASSB; dec_alu_src = 1'b1; dec_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm = imm_u; dec_alu_src = 1'b1; dec_reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm = imm_j; dec_reg_write = 1'b1; dec_jump = 1'b1; is_jal = 1'b1;
      end
      OPC_JALR: begin
        dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_jump = 1'b1;
        is_jalr = 1'b1; use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm = imm_b; dec_alu_op = ALU_SUB; is_branch = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_alu_src = 1'b1; dec_mem_read = 1'b1; dec_reg_write = 1'b1;
        dec_mem_to_reg = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm = imm_s; dec_alu_src = 1'b1; dec_mem_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        dec_alu_op  = {(inst_q[14:12] == 3'b101) & inst_q[30], inst_q[14:12]};
        dec_alu_src = 1'b1; dec_reg_write = 1'b1; use_rs1 = 1'b1;
      end
      OPC_OP: begin
        imm = '0; dec_alu_op = {inst_q[30], inst_q[14:12]}; dec_reg_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_FENCE: ;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    load_use = ex_mem_read && ex_rd != 5'd0 &&
               ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
    br_haz_1 = use_rs1 && ((ex_reg_write && ex_rd != 5'd0 && ex_rd == rs1) ||
                           (mem_mem_read && mem_rd != 5'd0 && mem_rd == rs1));
    br_haz_2 = use_rs2 && ((ex_reg_write && ex_rd != 5'd0 && ex_rd == rs2) ||
                           (mem_mem_read && mem_rd != 5'd0 && mem_rd == rs2));
    stall    = valid_q && (load_use || ((is_branch || is_jalr) && (br_haz_1 || br_haz_2)));
    ctrl_en  = valid_q && legal && !stall;
  end

  always_comb begin
    br_op1 = rs1_data;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs1) br_op1 = mem_alu_result;
    br_op2 = rs2_data;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs2) br_op2 = mem_alu_result;
    case (funct3)
      3'b000:  br_cond = (br_op1 == br_op2);
      3'b001:  br_cond = (br_op1 != br_op2);
      3'b100:  br_cond = ($signed(br_op1) <  $signed(br_op2));
      3'b101:  br_cond = ($signed(br_op1) >= $signed(br_op2));
      3'b110:  br_cond = (br_op1 <  br_op2);
      3'b111:  br_cond = (br_op1 >= br_op2);
      default: br_cond = 1'b0;
    endcase
    jalr_sum = br_op1 + imm;
    if (is_jalr) pc_imm = jalr_sum[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
    else         pc_imm = pc_q + imm[PC_WIDTH-1:0];
  end

  assign pc_sel      = ctrl_en && (is_jal || is_jalr || (is_branch && br_cond));
  assign IF_flush    = pc_sel;
  assign pc_write    = !stall;
  assign IF_ID_write = !stall;

  assign alu_op     = ctrl_en ? dec_alu_op : 4'd0;
  assign alu_src    = ctrl_en & dec_alu_src;
  assign mem_read   = ctrl_en & dec_mem_read;
  assign mem_write  = ctrl_en & dec_mem_write;
  assign reg_write  = ctrl_en & dec_reg_write;
  assign mem_to_reg = ctrl_en & dec_mem_to_reg;
  assign jump       = ctrl_en & dec_jump;
  assign illegal    = valid_q & ~legal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded RV32I instructions with hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] if_pc, if_pc_next, if_inst;
  logic        ex_mem_read, ex_reg_write, mem_mem_read, mem_reg_write, wb_reg_write;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [31:0] mem_alu_result, wb_data;
  logic        pc_sel, pc_write, IF_flush, IF_ID_write;
  logic [31:0] pc_imm, id_pc, id_pc_next, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, jump, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage dut (
    .clk(clk), .reset_n(reset_n),
    .if_pc(if_pc), .if_pc_next(if_pc_next), .if_inst(if_inst),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_sel(pc_sel), .pc_imm(pc_imm), .pc_write(pc_write), .IF_flush(IF_flush),
    .IF_ID_write(IF_ID_write), .id_pc(id_pc), .id_pc_next(id_pc_next),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .alu_op(alu_op),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    if_pc      = pc;
    if_pc_next = pc + 32'd4;
    if_inst    = inst;
    step();
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_reg_write = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    if_pc = 32'd0; if_pc_next = 32'd4; if_inst = 32'h0000_0013;
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    mem_mem_read = 0; mem_reg_write = 0; mem_rd = 0; mem_alu_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    #2;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_if_id_write", IF_ID_write, 1);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_flush", IF_flush, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_id_pc", id_pc, 0);
    step(); step();
    reset_n = 1'b1;

    // ADDI x1,x0,5
    fetch(32'h20, 32'h0050_0093);
    chk("addi_imm", imm, 5);
    chk("addi_rd", rd, 1);
    chk("addi_alu_src", alu_src, 1);
    chk("addi_reg_write", reg_write, 1);
    chk("addi_rs1_data", rs1_data, 0);
    chk("addi_id_pc", id_pc, 32'h20);
    chk("addi_id_pc_next", id_pc_next, 32'h24);

    if_inst = 32'h0000_0013;
    wb_write(5'd1, 32'h55);
    wb_write(5'd2, 32'h55);
    wb_write(5'd7, 32'h200);
    wb_write(5'd8, 32'hFFFF_FFFF);

    // ADD x4,x3,x0 with same-cycle write-back of x3
    fetch(32'h40, 32'h0001_8233);
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("wb_bypass", rs1_data, 32'hDEAD_BEEF);
    step();
    wb_reg_write = 1'b0;
    #1;
    chk("wb_stored", rs1_data, 32'hDEAD_BEEF);
    chk("add_alu_op", alu_op, 0);
    // ADD x4,x0,x0 while writing x0
    fetch(32'h44, 32'h0000_0233);
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    chk("x0_bypass", rs1_data, 0);
    step();
    wb_reg_write = 1'b0;
    #1;
    chk("x0_stored", rs1_data, 0);

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID
    fetch(32'h80, 32'h0012_8333);
    chk("add_rs1", rs1, 5);
    chk("add_rs2", rs2, 1);
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", IF_ID_write, 0);
    chk("lu_reg_write", reg_write, 0);
    fetch(32'h84, 32'h0050_0093);
    chk("lu_hold_rd", rd, 6);
    chk("lu_hold_pc", id_pc, 32'h80);
    chk("lu_still_stall", pc_write, 0);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_clear_pc_write", pc_write, 1);
    chk("lu_clear_reg_write", reg_write, 1);
    chk("lu_rs2_data", rs2_data, 32'h55);
    ex_reg_write = 1'b1;
    #1;
    chk("alu_dep_no_stall", pc_write, 1);
    ex_reg_write = 1'b0; ex_rd = 5'd0;

    // BEQ x1,x2,+16 at 0x100 (equal)
    fetch(32'h100, 32'h0020_8863);
    chk("beq_pc_sel", pc_sel, 1);
    chk("beq_pc_imm", pc_imm, 32'h110);
    chk("beq_flush", IF_flush, 1);
    chk("beq_imm", imm, 16);
    chk("beq_alu_op", alu_op, 4'b1000);
    fetch(32'h104, 32'h0050_0093);
    chk("flush_rd", rd, 0);
    chk("flush_reg_write", reg_write, 0);
    chk("flush_pc_sel", pc_sel, 0);
    // BNE x1,x2 (equal -> not taken)
    fetch(32'h108, 32'h0020_9863);
    chk("bne_not_taken", pc_sel, 0);
    // BLT x8,x1: -1 < 0x55 signed
    fetch(32'h10C, 32'h0014_4863);
    chk("blt_taken", pc_sel, 1);
    chk("blt_pc_imm", pc_imm, 32'h11C);
    fetch(32'h110, 32'h0000_0013);
    // BLTU x8,x1: 0xFFFFFFFF < 0x55 unsigned is false
    fetch(32'h114, 32'h0014_6863);
    chk("bltu_not_taken", pc_sel, 0);

    // JALR x1,x7,3 with x7=0x200
    fetch(32'h140, 32'h0033_80E7);
    chk("jalr_pc_imm", pc_imm, 32'h202);
    chk("jalr_jump", jump, 1);
    chk("jalr_pc_sel", pc_sel, 1);
    fetch(32'h144, 32'h0000_0013);
    chk("jalr_flush_jump", jump, 0);
    // JAL x1,-8 at 0x1C0
    fetch(32'h1C0, 32'hFF9F_F0EF);
    chk("jal_imm", imm, 32'hFFFF_FFF8);
    chk("jal_pc_imm", pc_imm, 32'h1B8);
    chk("jal_pc_sel", pc_sel, 1);
    fetch(32'h1C4, 32'h0000_0013);
    // SW x2,-4(x1)
    fetch(32'h200, 32'hFE20_AE23);
    chk("sw_imm", imm, 32'hFFFF_FFFC);
    chk("sw_mem_write", mem_write, 1);
    chk("sw_reg_write", reg_write, 0);
    chk("sw_funct3", funct3, 2);
    // LW x9,8(x1)
    fetch(32'h204, 32'h0080_A483);
    chk("lw_imm", imm, 8);
    chk("lw_mem_read", mem_read, 1);
    chk("lw_mem_to_reg", mem_to_reg, 1);
    // LUI x5,0x12345
    fetch(32'h208, 32'h1234_52B7);
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_reg_write", reg_write, 1);
    // Unsupported opcode
    fetch(32'h20C, 32'hFFFF_FFFF);
    chk("ill_flag", illegal, 1);
    chk("ill_reg_write", reg_write, 0);
    chk("ill_pc_sel", pc_sel, 0);

    // BNE x1,x2 with x1 forwarded from MEM
    fetch(32'h180, 32'h0020_9863);
    chk("bne_nofwd", pc_sel, 0);
    mem_reg_write = 1'b1; mem_rd = 5'd1; mem_alu_result = 32'h77;
    #1;
    chk("bne_fwd_taken", pc_sel, 1);
    chk("bne_fwd_pc_imm", pc_imm, 32'h190);
    ex_reg_write = 1'b1; ex_rd = 5'd2;
    #1;
    chk("br_haz_pc_write", pc_write, 0);
    chk("br_haz_pc_sel", pc_sel, 0);
    chk("br_haz_flush", IF_flush, 0);

    // Asynchronous reset in the middle of the stall
    reset_n = 1'b0;
    #1;
    chk("arst_pc_write", pc_write, 1);
    chk("arst_if_id_write", IF_ID_write, 1);
    chk("arst_id_pc", id_pc, 0);
    chk("arst_rd", rd, 0);
    chk("arst_imm", imm, 0);
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_reg_write = 1'b0; mem_rd = 5'd0;
    step();
    reset_n = 1'b1;
    fetch(32'h40, 32'h0001_8233);
    chk("arst_regs_cleared", rs1_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
